relogio_contador_hms: RTL and testbench

- Timekeeping core of the clock, directly downstream of the 1 s / 15 s tick generator.
- Consumes the 1 s tick as a synchronous enable and keeps time in BCD as hours:minutes:seconds (24 h format).
- Provides a two-button set-time state machine.
- Drives the display decoder stage with BCD digits and a mode indication.

---
 rtl/relogio_contador_hms_pkg.sv | 24 ++
 rtl/relogio_contador_hms_bcd_mod_counter.sv | 47 ++++
 rtl/relogio_contador_hms.sv | 122 ++++++++++++
 tb/tb_relogio_contador_hms.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/relogio_contador_hms_pkg.sv
// Shared definitions for the hours:minutes:seconds timekeeping core.
// Holds the mode encodings, the BCD constants and a binary-to-BCD helper
// used to turn the HOUR_MAX parameter into its two-digit BCD value.
package relogio_pkg;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'b00,
    MODE_SET_HOUR = 2'b01,
    MODE_SET_MIN  = 2'b10
  } mode_e;

  localparam logic [7:0] BCD_59   = 8'h59;
  localparam logic [7:0] BCD_ZERO = 8'h00;

  // Two-digit BCD of a small binary value (0..99).
  function automatic logic [7:0] to_bcd8(input int unsigned v);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = 4'((v / 10) % 10);
    units = 4'(v % 10);
    return {tens, units};
  endfunction

endpackage

// File: rtl/relogio_contador_hms_bcd_mod_counter.sv
// Two-digit BCD modulo counter, 00..MAX_BCD then back to 00.
// Ports:
//   clk, reset  - clock, asynchronous active-low reset
//   clr         - synchronous clear to 00 (wins over inc)
//   inc         - count enable for this cycle
//   value       - registered BCD count [7:4] tens, [3:0] units
//   carry       - combinational: inc while value == MAX_BCD
module bcd_mod_counter
  import relogio_pkg::*;
#(
  parameter logic [7:0] MAX_BCD = BCD_59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] value,
  output logic       carry
);

  logic [7:0] next_value;

  assign carry = inc && (value == MAX_BCD);

  // BCD +1 with wrap on the full 8-bit value.
  always_comb begin
    next_value = value;
    if (carry) begin
      next_value = BCD_ZERO;
    end else if (value[3:0] == 4'd9) begin
      next_value = {value[7:4] + 4'd1, 4'd0};
    end else begin
      next_value = {value[7:4], value[3:0] + 4'd1};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= BCD_ZERO;
    end else if (clr) begin
      value <= BCD_ZERO;
    end else if (inc) begin
      value <= next_value;
    end
  end

endmodule

// File: rtl/relogio_contador_hms.sv
// Timekeeping core: BCD hh:mm:ss driven by the 1 s tick, plus a two-button
// set-time state machine (mode cycles RUN -> SET_HOUR -> SET_MIN -> RUN,
// inc bumps the field being set).
// Ports:
//   clk, reset          - 27 MHz clock, asynchronous active-low reset
//   tick_1s             - one-cycle enable pulse per second
//   btn_mode, btn_inc   - raw asynchronous active-high buttons
//   hh_bcd/mm_bcd/ss_bcd- registered BCD time
//   mode                - 00 RUN, 01 SET_HOUR, 10 SET_MIN
//   min_pulse           - one-cycle pulse on the 59->00 seconds wrap in RUN
module relogio_contador_hms
  import relogio_pkg::*;
#(
  parameter int unsigned HOUR_MAX    = 23,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1s,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [7:0] hh_bcd,
  output logic [7:0] mm_bcd,
  output logic [7:0] ss_bcd,
  output logic [1:0] mode,
  output logic       min_pulse
);

  localparam logic [7:0] HOUR_MAX_BCD = to_bcd8(HOUR_MAX);

  logic [SYNC_STAGES-1:0] mode_sync;
  logic [SYNC_STAGES-1:0] inc_sync;
  logic                   mode_prev;
  logic                   inc_prev;
  logic                   mode_ev;
  logic                   inc_ev;
  mode_e                  state;

  logic run;
  logic ss_inc, ss_clr, ss_carry;
  logic mm_inc, mm_carry;
  logic hh_inc, unused_hh_carry;

  // Button synchronizers followed by rising-edge detectors.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_sync <= '0;
      inc_sync  <= '0;
      mode_prev <= 1'b0;
      inc_prev  <= 1'b0;
    end else begin
      mode_sync <= {mode_sync[SYNC_STAGES-2:0], btn_mode};
      inc_sync  <= {inc_sync[SYNC_STAGES-2:0], btn_inc};
      mode_prev <= mode_sync[SYNC_STAGES-1];
      inc_prev  <= inc_sync[SYNC_STAGES-1];
    end
  end

  assign mode_ev = mode_sync[SYNC_STAGES-1] & ~mode_prev;
  assign inc_ev  = inc_sync[SYNC_STAGES-1] & ~inc_prev;

  // Mode FSM; the stray encoding 11 falls back to RUN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= MODE_RUN;
    end else begin
      case (state)
        MODE_RUN:      if (mode_ev) state <= MODE_SET_HOUR;
        MODE_SET_HOUR: if (mode_ev) state <= MODE_SET_MIN;
        MODE_SET_MIN:  if (mode_ev) state <= MODE_RUN;
        default:       state <= MODE_RUN;
      endcase
    end
  end

  assign mode = state;
  assign run  = (state == MODE_RUN);

  // Counter enables: a mode event swallows a same-cycle inc event; carries
  // only ripple while running.
  assign ss_inc = run & tick_1s;
  assign ss_clr = (state == MODE_SET_MIN) & mode_ev;
  assign mm_inc = ss_carry | ((state == MODE_SET_MIN) & inc_ev & ~mode_ev);
  assign hh_inc = (run & mm_carry) | ((state == MODE_SET_HOUR) & inc_ev & ~mode_ev);

  bcd_mod_counter #(.MAX_BCD(BCD_59)) u_ss (
    .clk  (clk),
    .reset(reset),
    .clr  (ss_clr),
    .inc  (ss_inc),
    .value(ss_bcd),
    .carry(ss_carry)
  );

  bcd_mod_counter #(.MAX_BCD(BCD_59)) u_mm (
    .clk  (clk),
    .reset(reset),
    .clr  (1'b0),
    .inc  (mm_inc),
    .value(mm_bcd),
    .carry(mm_carry)
  );

  bcd_mod_counter #(.MAX_BCD(HOUR_MAX_BCD)) u_hh (
    .clk  (clk),
    .reset(reset),
    .clr  (1'b0),
    .inc  (hh_inc),
    .value(hh_bcd),
    .carry(unused_hh_carry)
  );

  // ss_carry is already gated to RUN through ss_inc.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      min_pulse <= 1'b0;
    end else begin
      min_pulse <= ss_carry;
    end
  end

endmodule

// File: tb/tb_relogio_contador_hms.sv
// Bench for relogio_contador_hms: a driver updates a decimal reference model
// each cycle and queues the expected outputs; a monitor pops and compares.
module tb_relogio_contador_hms;

  localparam int unsigned HOUR_MAX = 23;
  localparam int unsigned S        = 2;

  logic       clk;
  logic       reset;
  logic       tick_1s;
  logic       btn_mode;
  logic       btn_inc;
  logic [7:0] hh_bcd;
  logic [7:0] mm_bcd;
  logic [7:0] ss_bcd;
  logic [1:0] mode;
  logic       min_pulse;

  relogio_contador_hms #(.HOUR_MAX(HOUR_MAX), .SYNC_STAGES(S)) dut (
    .clk      (clk),
    .reset    (reset),
    .tick_1s  (tick_1s),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .hh_bcd   (hh_bcd),
    .mm_bcd   (mm_bcd),
    .ss_bcd   (ss_bcd),
    .mode     (mode),
    .min_pulse(min_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
    logic [1:0] md;
    logic       mp;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   pulse_cnt = 0;

  // Reference model: plain decimal time, mode 0/1/2, raw button history.
  int m_hh, m_mm, m_ss, m_mode;
  bit m_pulse;
  bit hm[$];
  bit hi[$];

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_hh = 0; m_mm = 0; m_ss = 0; m_mode = 0; m_pulse = 0;
    hm.delete(); hi.delete();
    for (int k = 0; k < int'(S) + 2; k++) begin
      hm.push_back(1'b0);
      hi.push_back(1'b0);
    end
  endtask

  // One clock edge of the model; a button level sampled at edge n becomes
  // an event at edge n+S if it was low at edge n-1.
  task automatic model_edge(input bit t, input bit m, input bit i);
    bit mev, iev;
    hm.push_front(m);
    hi.push_front(i);
    mev = hm[S] && !hm[S+1];
    iev = hi[S] && !hi[S+1];
    void'(hm.pop_back());
    void'(hi.pop_back());
    m_pulse = 1'b0;
    if (m_mode == 0 && t) begin
      m_ss++;
      if (m_ss == 60) begin
        m_ss = 0;
        m_pulse = 1'b1;
        m_mm++;
        if (m_mm == 60) begin
          m_mm = 0;
          m_hh++;
          if (m_hh > int'(HOUR_MAX)) m_hh = 0;
        end
      end
    end
    if (mev) begin
      if (m_mode == 2) m_ss = 0;
      m_mode = (m_mode + 1) % 3;
    end else if (iev) begin
      if (m_mode == 1) m_hh = (m_hh + 1) % (int'(HOUR_MAX) + 1);
      else if (m_mode == 2) m_mm = (m_mm + 1) % 60;
    end
  endtask

  task automatic step(input bit t, input bit m, input bit i);
    exp_t e;
    @(negedge clk);
    tick_1s  = t;
    btn_mode = m;
    btn_inc  = i;
    model_edge(t, m, i);
    e.hh = bcd(m_hh); e.mm = bcd(m_mm); e.ss = bcd(m_ss);
    e.md = 2'(m_mode); e.mp = m_pulse;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic press(input bit m, input bit i, input bit t);
    step(t, m, i);
    step(1'b0, m, i);
    step(1'b0, m, i);
    repeat (3) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_hh"}, hh_bcd, 8'h00);
    chk({tag, "_mm"}, mm_bcd, 8'h00);
    chk({tag, "_ss"}, ss_bcd, 8'h00);
    chk({tag, "_mode"}, mode, 2'b00);
    chk({tag, "_min_pulse"}, min_pulse, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    reset    = 1'b0;
    tick_1s  = 1'b0;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    #1;
    chk_zero(tag);
    model_reset();
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  // Monitor: every clocked output is compared against the queued model.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (reset === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_hh", hh_bcd, e.hh);
      chk("sb_mm", mm_bcd, e.mm);
      chk("sb_ss", ss_bcd, e.ss);
      chk("sb_mode", mode, e.md);
      chk("sb_min_pulse", min_pulse, e.mp);
    end
    if (min_pulse === 1'b1) pulse_cnt++;
  end

  initial begin
    int p0;
    reset    = 1'b0;
    tick_1s  = 1'b0;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    model_reset();
    #1;
    chk_zero("reset");
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // 60 ticks: ss 00..59 -> 00, mm 01, one min_pulse
    p0 = pulse_cnt;
    for (int k = 0; k < 60; k++) begin
      step(1'b1, 1'b0, 1'b0);
      repeat (4) step(1'b0, 1'b0, 1'b0);
    end
    chk("minute_mm", mm_bcd, 8'h01);
    chk("minute_ss", ss_bcd, 8'h00);
    chk("minute_pulses", pulse_cnt - p0, 1);
    repeat (3) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end

    // Held mode button: one event, SYNC_STAGES+1 edges after the rise
    for (int k = 1; k <= 50; k++) begin
      step(1'b0, 1'b1, 1'b0);
      if (k == int'(S)) chk("mode_before_sync", mode, 2'b00);
      if (k == int'(S) + 1) chk("mode_after_sync", mode, 2'b01);
    end
    repeat (3) step(1'b0, 1'b0, 1'b0);
    chk("mode_held", mode, 2'b01);

    // SET_HOUR: 25 incs wrap 00 -> 01, ticks ignored
    for (int k = 0; k < 25; k++) press(1'b0, 1'b1, 1'b1);
    chk("set_hour_wrap", hh_bcd, 8'h01);
    chk("set_hour_ss_frozen", ss_bcd, 8'h03);

    // Preload 23:59 then full rollover
    for (int k = 0; k < 22; k++) press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 58; k++) press(1'b0, 1'b1, 1'b0);
    chk("preload_mm", mm_bcd, 8'h59);
    press(1'b1, 1'b0, 1'b0);
    chk("preload_hh", hh_bcd, 8'h23);
    chk("preload_ss_clr", ss_bcd, 8'h00);
    chk("preload_mode", mode, 2'b00);
    p0 = pulse_cnt;
    for (int k = 0; k < 60; k++) begin
      step(1'b1, 1'b0, 1'b0);
      repeat (4) step(1'b0, 1'b0, 1'b0);
    end
    chk("rollover_hh", hh_bcd, 8'h00);
    chk("rollover_mm", mm_bcd, 8'h00);
    chk("rollover_ss", ss_bcd, 8'h00);
    chk("rollover_pulses", pulse_cnt - p0, 1);

    // Same-cycle mode+inc in SET_MIN with mm=10
    repeat (7) step(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) press(1'b0, 1'b1, 1'b0);
    chk("setmin_mm", mm_bcd, 8'h10);
    press(1'b1, 1'b1, 1'b0);
    chk("both_mode", mode, 2'b00);
    chk("both_mm", mm_bcd, 8'h10);
    chk("both_ss", ss_bcd, 8'h00);

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0);
    end
    repeat (6) step(1'b0, 1'b0, 1'b0);

    // Reset mid-count at 12:34:56 with a mode edge in the synchronizer
    do_reset("reset2");
    press(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 12; k++) press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 34; k++) press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 56; k++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
    chk("t123456_hh", hh_bcd, 8'h12);
    chk("t123456_mm", mm_bcd, 8'h34);
    chk("t123456_ss", ss_bcd, 8'h56);
    step(1'b0, 1'b1, 1'b0);
    do_reset("reset_mid");
    repeat (10) step(1'b0, 1'b0, 1'b0);
    chk("post_reset_mode", mode, 2'b00);
    chk("post_reset_hh", hh_bcd, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
